// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: bus widths, RAM op codes and FSM/port encodings shared by mem_arbiter.
package mem_arbiter_pkg;
    localparam int DATA_BUS = 16;
    localparam int ADDR_BUS = 18;
    localparam logic RAM_OP_RD = 1'b0;
    localparam logic RAM_OP_WR = 1'b1;
    typedef enum logic [1:0] {ARB_S_IDLE, ARB_S_ISSUE, ARB_S_WAIT, ARB_S_DONE} arb_state_e;
    typedef enum logic {PORT_IF, PORT_MEM} port_e;
endpackage

// File: rtl/mem_arbiter_fetch_buf.sv
// mem_arbiter_fetch_buf: single-entry fetch buffer (tag, word, valid) with hit compare.
// Instantiated by mem_arbiter only when MEM_ARBITER_FETCH_BUF_EN is defined.
module mem_arbiter_fetch_buf
    import mem_arbiter_pkg::*;
(
    input  logic                clk_50MHz,
    input  logic                rst,
    input  logic [ADDR_BUS-1:0] lookup_addr_i,
    input  logic                fill_i,
    input  logic [ADDR_BUS-1:0] fill_addr_i,
    input  logic [DATA_BUS-1:0] fill_data_i,
    input  logic                clear_i,
    output logic                hit_o,
    output logic [DATA_BUS-1:0] data_o
);
    logic [ADDR_BUS-1:0] tag_q, tag_d;
    logic [DATA_BUS-1:0] data_q, data_d;
    logic                valid_q, valid_d;

    assign tag_d   = fill_i ? fill_addr_i : tag_q;
    assign data_d  = fill_i ? fill_data_i : data_q;
    assign valid_d = fill_i ? 1'b1 : clear_i ? 1'b0 : valid_q;
    assign hit_o   = valid_q && (tag_q == lookup_addr_i);
    assign data_o  = data_q;

    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF fetches and MEM loads/stores onto one SRAM controller port.
// Defining MEM_ARBITER_FETCH_BUF_EN adds a single-entry fetch buffer giving 1-cycle fetch hits.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                clk_50MHz,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_BUS-1:0] if_addr,
    output logic [DATA_BUS-1:0] if_data,
    output logic                if_ready,
    output logic                if_stall,
    input  logic                mem_req,
    input  logic                mem_op,
    input  logic [ADDR_BUS-1:0] mem_addr,
    input  logic [DATA_BUS-1:0] mem_wdata,
    output logic [DATA_BUS-1:0] mem_rdata,
    output logic                mem_ready,
    output logic                mem_stall,
    output logic                ram_en,
    output logic                ram_op,
    output logic [ADDR_BUS-1:0] ram_addr,
    output logic [DATA_BUS-1:0] ram_wdata,
    input  logic [DATA_BUS-1:0] ram_rdata
);
    arb_state_e          state_q, state_d;
    port_e               served_q, served_d;
    logic                ram_op_q, ram_op_d;
    logic [ADDR_BUS-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_BUS-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_BUS-1:0] if_data_q, if_data_d;
    logic [DATA_BUS-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_BUS-1:0] buf_data;
    logic                grant_slot, mem_ok, if_ok, wait_if, wait_mem, hit;

    assign grant_slot = (state_q == ARB_S_IDLE) || (state_q == ARB_S_DONE);
    // a request still held during its own DONE cycle must not be replayed
    assign mem_ok   = grant_slot && mem_req && !(state_q == ARB_S_DONE && served_q == PORT_MEM);
    assign if_ok    = grant_slot && if_req && !(state_q == ARB_S_DONE && served_q == PORT_IF);
    assign wait_if  = (state_q == ARB_S_WAIT) && (served_q == PORT_IF);
    assign wait_mem = (state_q == ARB_S_WAIT) && (served_q == PORT_MEM);

`ifdef MEM_ARBITER_FETCH_BUF_EN
    mem_arbiter_fetch_buf u_fetch_buf (
        .clk_50MHz     (clk_50MHz),
        .rst           (rst),
        .lookup_addr_i (if_addr),
        .fill_i        (wait_if),
        .fill_addr_i   (ram_addr_q),
        .fill_data_i   (ram_rdata),
        .clear_i       (wait_mem && ram_op_q == RAM_OP_WR),
        .hit_o         (hit),
        .data_o        (buf_data)
    );
`else
    assign hit      = 1'b0;
    assign buf_data = '0;
`endif

    always_comb begin
        state_d     = state_q;
        served_d    = served_q;
        ram_op_d    = ram_op_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_data_d   = wait_if ? ram_rdata : if_data_q;
        mem_rdata_d = (wait_mem && ram_op_q == RAM_OP_RD) ? ram_rdata : mem_rdata_q;
        case (state_q)
            ARB_S_ISSUE: state_d = ARB_S_WAIT;
            ARB_S_WAIT:  state_d = ARB_S_DONE;
            default: begin
                state_d = ARB_S_IDLE;
                if (mem_ok) begin
                    state_d     = ARB_S_ISSUE;
                    served_d    = PORT_MEM;
                    ram_op_d    = mem_op;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                end else if (if_ok && hit) begin
                    state_d   = ARB_S_DONE;
                    served_d  = PORT_IF;
                    if_data_d = buf_data;
                end else if (if_ok) begin
                    state_d    = ARB_S_ISSUE;
                    served_d   = PORT_IF;
                    ram_op_d   = RAM_OP_RD;
                    ram_addr_d = if_addr;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            state_q     <= ARB_S_IDLE;
            served_q    <= PORT_IF;
            ram_op_q    <= RAM_OP_RD;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            served_q    <= served_d;
            ram_op_q    <= ram_op_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_en    = state_q == ARB_S_ISSUE;
    assign ram_op    = ram_op_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = (state_q == ARB_S_DONE) && (served_q == PORT_IF);
    assign mem_ready = (state_q == ARB_S_DONE) && (served_q == PORT_MEM);
    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_req & ~mem_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level model.
// The model follows MEM_ARBITER_FETCH_BUF_EN so the bench fits either build.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;
`ifdef MEM_ARBITER_FETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif
    typedef logic [ADDR_BUS-1:0] addr_t;
    typedef logic [DATA_BUS-1:0] data_t;
    typedef struct { data_t data; int cyc; } exp_t;
    typedef struct { logic op; addr_t addr; data_t wdata; bit chk_w; } ram_t;

    logic clk_50MHz = 1'b0;
    logic rst = 1'b0;
    logic if_req = 1'b0;
    addr_t if_addr = '0;
    data_t if_data;
    logic if_ready, if_stall;
    logic mem_req = 1'b0;
    logic mem_op = 1'b0;
    addr_t mem_addr = '0;
    data_t mem_wdata = '0;
    data_t mem_rdata;
    logic mem_ready, mem_stall;
    logic ram_en, ram_op;
    addr_t ram_addr;
    data_t ram_wdata;
    data_t ram_rdata;

    exp_t if_q[$];
    exp_t mem_q[$];
    ram_t ram_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    data_t ref_mem [addr_t];
    bit bv = 1'b0;
    addr_t bt = '0;
    data_t bd = '0;
    data_t last_rd = '0;
    data_t sram [0:262143];
    bit wr_v [0:262143];
    logic en_prev;
    logic h_op;
    addr_t h_addr;
    data_t h_wdata;

    mem_arbiter dut (
        .clk_50MHz (clk_50MHz), .rst (rst),
        .if_req (if_req), .if_addr (if_addr), .if_data (if_data), .if_ready (if_ready), .if_stall (if_stall),
        .mem_req (mem_req), .mem_op (mem_op), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .mem_ready (mem_ready), .mem_stall (mem_stall),
        .ram_en (ram_en), .ram_op (ram_op), .ram_addr (ram_addr), .ram_wdata (ram_wdata), .ram_rdata (ram_rdata)
    );

    always #10 clk_50MHz = ~clk_50MHz;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    function automatic data_t pattern(addr_t a);
        return (a == 18'h00010) ? 16'h1234 : (a[15:0] ^ 16'h5A5A);
    endfunction

    function automatic data_t ref_rd(addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
    endfunction

    // SRAM controller: read data appears during the cycle after the strobe
    always @(posedge clk_50MHz) begin
        if (ram_en && ram_op == RAM_OP_WR) begin
            sram[ram_addr] <= ram_wdata;
            wr_v[ram_addr] <= 1'b1;
        end else if (ram_en) begin
            ram_rdata <= wr_v[ram_addr] ? sram[ram_addr] : pattern(ram_addr);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_50MHz) begin : mon
        ram_t mr;
        exp_t me;
        if (!rst) begin
            en_prev <= 1'b0;
        end else begin
            chk("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~if_ready});
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, mem_req & ~mem_ready});
            if (en_prev) begin
                chk("ram_en_gap", {31'b0, ram_en}, 32'd0);
                chk("ram_op_hold", {31'b0, ram_op}, {31'b0, h_op});
                chk("ram_addr_hold", {14'b0, ram_addr}, {14'b0, h_addr});
                chk("ram_wdata_hold", {16'b0, ram_wdata}, {16'b0, h_wdata});
            end
            en_prev <= ram_en;
            h_op    <= ram_op;
            h_addr  <= ram_addr;
            h_wdata <= ram_wdata;
            if (ram_en && ram_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ram_en_unexpected: got ram_en=1 at cycle %0d expected no access", cyc);
            end else if (ram_en) begin
                mr = ram_q.pop_front();
                chk("ram_op", {31'b0, ram_op}, {31'b0, mr.op});
                chk("ram_addr", {14'b0, ram_addr}, {14'b0, mr.addr});
                if (mr.chk_w) chk("ram_wdata", {16'b0, ram_wdata}, {16'b0, mr.wdata});
            end
            if (if_ready && if_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL if_ready_unexpected: got if_ready=1 at cycle %0d expected none", cyc);
            end else if (if_ready) begin
                me = if_q.pop_front();
                chk("if_data", {16'b0, if_data}, {16'b0, me.data});
                chk("if_ready_cycle", cyc, me.cyc);
            end
            if (mem_ready && mem_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_ready_unexpected: got mem_ready=1 at cycle %0d expected none", cyc);
            end else if (mem_ready) begin
                me = mem_q.pop_front();
                chk("mem_rdata", {16'b0, mem_rdata}, {16'b0, me.data});
                chk("mem_ready_cycle", cyc, me.cyc);
            end
        end
    end

    // reference model: each access starts when it has arrived and the previous one has completed
    function automatic int model_mem(int arr, int free, logic op, addr_t a, data_t wd);
        int st = (arr > free) ? arr : free;
        ram_q.push_back('{op, a, wd, 1'b1});
        if (op == RAM_OP_WR) begin
            ref_mem[a] = wd;
            bv = 1'b0;
        end else begin
            last_rd = ref_rd(a);
        end
        mem_q.push_back('{last_rd, st + 3});
        return st + 3;
    endfunction

    function automatic int model_if(int arr, int free, addr_t a);
        int st = (arr > free) ? arr : free;
        int dur = 3;
        data_t d;
        if (BUF_EN && bv && bt == a) begin
            dur = 1;
            d = bd;
        end else begin
            d = ref_rd(a);
            ram_q.push_back('{RAM_OP_RD, a, 16'h0, 1'b0});
            bv = 1'b1;
            bt = a;
            bd = d;
        end
        if_q.push_back('{d, st + dur});
        return st + dur;
    endfunction

    task automatic drive_mem(int off, logic op, addr_t a, data_t d);
        int n = 0;
        repeat (off) @(posedge clk_50MHz);
        #1;
        mem_req = 1'b1; mem_op = op; mem_addr = a; mem_wdata = d;
        do begin @(negedge clk_50MHz); n++; end while (!mem_ready && n < 30);
        if (!mem_ready) begin
            checks++; errors++;
            $display("FAIL mem_timeout: got no mem_ready in %0d cycles expected one", n);
        end
        @(posedge clk_50MHz); #1;
        mem_req = 1'b0;
    endtask

    task automatic drive_if(int off, addr_t a);
        int n = 0;
        repeat (off) @(posedge clk_50MHz);
        #1;
        if_req = 1'b1; if_addr = a;
        do begin @(negedge clk_50MHz); n++; end while (!if_ready && n < 30);
        if (!if_ready) begin
            checks++; errors++;
            $display("FAIL if_timeout: got no if_ready in %0d cycles expected one", n);
        end
        @(posedge clk_50MHz); #1;
        if_req = 1'b0;
    endtask

    task automatic scenario(bit dm, int om, logic op, addr_t ma, data_t wd, bit df, int of, addr_t fa);
        int base, free;
        @(posedge clk_50MHz); #1;
        base = cyc;
        free = 0;
        if (dm && (!df || om <= of)) begin
            free = model_mem(base + om, free, op, ma, wd);
            if (df) free = model_if(base + of, free, fa);
        end else begin
            if (df) free = model_if(base + of, free, fa);
            if (dm) free = model_mem(base + om, free, op, ma, wd);
        end
        fork
            if (dm) drive_mem(om, op, ma, wd);
            if (df) drive_if(of, fa);
        join
    endtask

    task automatic check_reset();
        chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rst_ram_op", {31'b0, ram_op}, {31'b0, RAM_OP_RD});
        chk("rst_ram_addr", {14'b0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", {16'b0, ram_wdata}, 32'd0);
        chk("rst_if_data", {16'b0, if_data}, 32'd0);
        chk("rst_mem_rdata", {16'b0, mem_rdata}, 32'd0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    endtask

    task automatic reset_in_wait();
        @(posedge clk_50MHz); #1;
        mem_req = 1'b1; mem_op = RAM_OP_RD; mem_addr = 18'h00300; mem_wdata = 16'h0;
        ram_q.push_back('{RAM_OP_RD, 18'h00300, 16'h0, 1'b1});
        @(posedge clk_50MHz);
        @(posedge clk_50MHz); #1;
        rst = 1'b0;
        mem_req = 1'b0;
        @(posedge clk_50MHz); #1;
        rst = 1'b1;
        @(negedge clk_50MHz);
        check_reset();
        last_rd = '0;
        bv = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        check_reset();
        @(posedge clk_50MHz); #1;
        rst = 1'b1;
        scenario(0, 0, RAM_OP_RD, '0, '0, 1, 0, 18'h00010);
        chk("fetch_1234", {16'b0, if_data}, 32'h1234);
        scenario(1, 0, RAM_OP_WR, 18'h00200, 16'hBEEF, 0, 0, '0);
        scenario(1, 0, RAM_OP_RD, 18'h00200, 16'h0, 0, 0, '0);
        chk("load_beef", {16'b0, mem_rdata}, 32'hBEEF);
        scenario(1, 0, RAM_OP_RD, 18'h00300, 16'h0, 1, 0, 18'h00004);
        scenario(0, 0, RAM_OP_RD, '0, '0, 1, 0, 18'h00010);
        scenario(0, 0, RAM_OP_RD, '0, '0, 1, 0, 18'h00010);
        scenario(1, 0, RAM_OP_WR, 18'h00777, 16'h5555, 0, 0, '0);
        scenario(0, 0, RAM_OP_RD, '0, '0, 1, 0, 18'h00010);
        reset_in_wait();
        scenario(0, 0, RAM_OP_RD, '0, '0, 1, 0, 18'h00010);
        scenario(1, 0, RAM_OP_RD, 18'h00200, 16'h0, 0, 0, '0);
        for (int i = 0; i < 80; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            scenario(kind != 0, $urandom_range(0, 4), logic'($urandom_range(0, 1)),
                     addr_t'(18'h00200 + $urandom_range(0, 3)), data_t'($urandom),
                     kind != 1, $urandom_range(0, 4), addr_t'(18'h00010 + 4 * $urandom_range(0, 3)));
        end
        repeat (3) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        chk("ram_q_drained", ram_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
